// File: rtl/mandel_pkg.sv
// mandel_pkg: types and helpers shared by the Mandelbrot engine, the colour
// mapper and the testbench.
//   state_t : iteration FSM states
//   thresh  : escape threshold |z|^2 > 4 as a square of Q(.frac) values (4 << 2*frac)
//   crop    : takes a 2*DW-bit product back to a Q(DW-frac).frac word
//             (bits [dw+frac-1:frac]); caller narrows the result to its DW
package mandel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [127:0] thresh(input int frac);
    return 128'(4) << (2 * frac);
  endfunction

  function automatic logic [63:0] crop(input logic signed [127:0] prod,
                                       input int dw, input int frac);
    logic [63:0] mask;
    mask = (dw >= 64) ? '1 : ((64'(1) << dw) - 64'(1));
    return 64'(prod >>> frac) & mask;
  endfunction

endpackage

// File: rtl/mandel_sq_mul.sv
// mandel_sq_mul: registered product stage of the escape-time iteration.
//   sysclk, reset : clock, async active-high reset (products clear to 0)
//   en            : load enable (engine in MUL)
//   re_z, im_z    : current z
//   re2, im2, cr  : re_z^2, im_z^2, 2*re_z*im_z, full 2*DW-bit signed
// Kept separate so the multiplier mapping/pipelining can change on its own.
module mandel_sq_mul #(
  parameter int DW = 32
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   en,
  input  logic signed [DW-1:0]   re_z,
  input  logic signed [DW-1:0]   im_z,
  output logic signed [2*DW-1:0] re2,
  output logic signed [2*DW-1:0] im2,
  output logic signed [2*DW-1:0] cr
);

  logic signed [2*DW-1:0] re_x;
  logic signed [2*DW-1:0] im_x;
  logic signed [2*DW-1:0] re_im;

  assign re_x  = (2*DW)'(re_z);
  assign im_x  = (2*DW)'(im_z);
  assign re_im = re_x * im_x;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      re2 <= '0;
      im2 <= '0;
      cr  <= '0;
    end else if (en) begin
      re2 <= re_x * re_x;
      im2 <= im_x * im_x;
      // 2*re*im may wrap at 2*DW bits; only the cropped middle bits are used
      cr  <= re_im <<< 1;
    end
  end

endmodule

// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: Mandelbrot escape-time engine. Accepts one point c with
// pixel tags, iterates z <- z^2 + c from z=0 and returns the escape depth.
//   sysclk, reset        : clock, async active-high reset
//   in_valid/in_ready    : point handshake (ready only in IDLE)
//   in_x, in_y           : pixel tags, returned unchanged
//   in_re_c, in_im_c     : signed Q(DW-FRAC).FRAC c
//   max_iter             : iteration limit, sampled on accept
//   out_valid/out_ready  : result handshake, outputs held while stalled
//   out_x, out_y         : tags of the result
//   out_depth            : iteration at which |z|^2 > 4, or max_iter
//   out_escaped          : 1 = escaped, 0 = hit max_iter
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int IW   = 10,
  parameter int XW   = 10,
  parameter int YW   = 9
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XW-1:0]        in_x,
  input  logic [YW-1:0]        in_y,
  input  logic signed [DW-1:0] in_re_c,
  input  logic signed [DW-1:0] in_im_c,
  input  logic [IW-1:0]        max_iter,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y,
  output logic [IW-1:0]        out_depth,
  output logic                 out_escaped
);

  // Four integer bits keep |z| <= 2 plus c representable; helpers work in 64 bits
  if ((DW - FRAC < 4) || (DW > 64)) begin : g_bad_format
    $error("mandel_iter_engine: need DW-FRAC >= 4 and DW <= 64");
  end

  localparam logic [2*DW:0] THRESH = (2*DW+1)'(thresh(FRAC));

  state_t                 state;
  logic signed [DW-1:0]   re_c_q, im_c_q, re_z, im_z;
  logic [IW-1:0]          n, max_iter_q;
  logic [XW-1:0]          x_q;
  logic [YW-1:0]          y_q;
  logic signed [2*DW-1:0] re2, im2, cr, re_diff;
  logic [2*DW:0]          mag;
  logic signed [DW-1:0]   re_next, im_next;

  mandel_sq_mul #(.DW(DW)) u_sq_mul (
    .sysclk (sysclk),
    .reset  (reset),
    .en     (state == MUL),
    .re_z   (re_z),
    .im_z   (im_z),
    .re2    (re2),
    .im2    (im2),
    .cr     (cr)
  );

  // Both squares are non-negative, so one extra bit makes the sum exact
  assign mag     = {1'b0, re2} + {1'b0, im2};
  assign re_diff = re2 - im2;
  assign re_next = DW'(crop(128'(re_diff), DW, FRAC)) + re_c_q;
  assign im_next = DW'(crop(128'(cr), DW, FRAC)) + im_c_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_depth   <= '0;
      out_escaped <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      re_c_q      <= '0;
      im_c_q      <= '0;
      re_z        <= '0;
      im_z        <= '0;
      n           <= '0;
      max_iter_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            re_c_q     <= in_re_c;
            im_c_q     <= in_im_c;
            max_iter_q <= max_iter;
            x_q        <= in_x;
            y_q        <= in_y;
            re_z       <= '0;
            im_z       <= '0;
            n          <= '0;
            in_ready   <= 1'b0;
            state      <= MUL;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MUL: state <= ADD;
        ADD: begin
          // Escape is tested before the limit, so escaping at n==max_iter reports escaped
          if (mag > THRESH || n == max_iter_q) begin
            out_depth   <= n;
            out_escaped <= (mag > THRESH);
            out_x       <= x_q;
            out_y       <= y_q;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            re_z  <= re_next;
            im_z  <= im_next;
            n     <= n + 1'b1;
            state <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
